router_ilck_tx: RTL and testbench
=================================

ROUTER_ILCK_TX -- requirements
Module: router_ilck_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, flit payload width in bits.
REQ-002 SHALL have parameter CREDITS, default 4, receiver buffer slots (credits granted at reset), range 1..15.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, local transmit buffer entries, power of two, range 2..16.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 SHALL have port in_valid  input  1  local flit offered.
REQ-007 SHALL have port in_data  input  DATA_WIDTH  local flit payload.
REQ-008 SHALL have port in_ready  output  1  buffer can accept a flit this cycle.
REQ-009 SHALL have port link_up  input  1  downstream receiver enabled; level-sensitive.
REQ-010 SHALL have port credit_in  input  1  one-cycle pulse, one credit returned per high cycle.
REQ-011 SHALL have port link_valid  output  1  registered; flit present on link this cycle.
REQ-012 SHALL have port link_data  output  DATA_WIDTH  registered link payload.
REQ-013 SHALL have port credit_cnt  output  4  current available credits.
REQ-014 SHALL have port credit_err  output  1  sticky credit-overflow flag.

Function
REQ-015 SHALL accept a flit when in_valid and in_ready are both 1 at a rising edge; in_ready SHALL equal (fifo occupancy < FIFO_DEPTH), derived from registered state only.
REQ-016 SHALL store accepted flits in FIFO order; a flit written at edge N is eligible to send no earlier than edge N+1 (no fall-through).
REQ-017 SHALL send at an edge when FIFO non-empty, credit_cnt > 0, link_up = 1 and state = RUN: pop head, link_valid <= 1, link_data <= head.
REQ-018 SHALL drive link_valid <= 0 at any edge where no send occurs; link_data SHALL hold its last value when link_valid is 0.
REQ-019 SHALL allow back-to-back sends, one flit per cycle, while conditions of REQ-017 hold.
REQ-020 SHALL update credit_cnt <= credit_cnt - send + credit_in each edge; simultaneous send and credit_in leave it unchanged.
REQ-021 SHALL, on credit_in when credit_cnt = CREDITS and no send that edge, keep credit_cnt at CREDITS and set credit_err <= 1; credit_err clears only on reset.
REQ-022 SHALL permit simultaneous push and pop in one edge with occupancy unchanged; push on full is impossible by REQ-015.
REQ-023 SHALL implement states: IDLE (link_up low, no sends, pushes still accepted), RUN (sending allowed), STALL (link_up high, credit_cnt = 0 and FIFO non-empty).
REQ-024 SHALL transition IDLE->RUN at the edge where link_up = 1; RUN->STALL when a send leaves credit_cnt = 0 with FIFO still non-empty; STALL->RUN at the edge after credit_in; any state->IDLE when link_up = 0.
REQ-025 SHALL keep a flit sent at the edge where link_up falls counted as sent; link_up deassertion SHALL NOT drop buffered flits or alter credit_cnt.
REQ-026 SHALL count credit_in in every state including IDLE.

Reset
REQ-027 SHALL, while reset = 0, force: state IDLE, FIFO empty, in_ready 1, link_valid 0, link_data all zero, credit_cnt = CREDITS, credit_err 0.
REQ-028 SHALL apply reset asynchronously on assertion and release it synchronously to clk; reset mid-transfer SHALL discard all buffered flits.

Verification
REQ-029 SHALL verify: reset, link_up=1, push 0xA1,0xA2,0xA3 on consecutive edges -> link_valid high on edges 2,3,4 carrying 0xA1,0xA2,0xA3; credit_cnt 4->1.
REQ-030 SHALL verify: 6 flits pushed, no credit_in -> exactly 4 sent, state STALL, credit_cnt 0; one credit_in pulse -> fifth flit sent the edge after STALL->RUN.
REQ-031 SHALL verify: credit_in on the same edge as a send at credit_cnt=2 -> credit_cnt stays 2, credit_err 0.
REQ-032 SHALL verify: credit_in with credit_cnt=4 and no send -> credit_cnt 4, credit_err 1 and stays 1 until reset.
REQ-033 SHALL verify: link_up=0, push 4 flits -> in_ready 0, link_valid 0; raise link_up -> all 4 sent in order, in_ready returns 1.
REQ-034 SHALL verify: reset asserted with 3 flits buffered and credit_cnt 1 -> immediately link_valid 0, credit_cnt 4, in_ready 1; no stale flit sent after release.

Source files
------------

// File: rtl/router_ilck_tx.sv
// Credit-based link transmitter: buffers local flits in a small FIFO and
// forwards them one per cycle while the link is up and the receiver has
// buffer credits. Credits return as single-cycle pulses on credit_in.
module router_ilck_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int CREDITS    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  link_up,
  input  logic                  credit_in,
  output logic                  link_valid,
  output logic [DATA_WIDTH-1:0] link_data,
  output logic [3:0]            credit_cnt,
  output logic                  credit_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0]    CRED_MAX = 4'(CREDITS);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  link_valid_q, link_valid_d;
  logic [DATA_WIDTH-1:0] link_data_q, link_data_d;
  logic [3:0]            credit_q, credit_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic push, send;

  // Handshake and send qualification, all from registered state
  always_comb begin
    in_ready = (count_q != DEPTH_C);
    push     = in_valid && in_ready;
    send     = (count_q != '0) && (credit_q != '0) && link_up && (state_q == RUN);
  end

  // FIFO pointers, link register and credit accounting
  always_comb begin
    wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d     = send ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d      = count_q;
    if (push && !send) count_d = count_q + CW'(1);
    if (!push && send) count_d = count_q - CW'(1);
    link_valid_d = send;
    link_data_d  = send ? mem_q[rd_ptr_q] : link_data_q;
    credit_d     = credit_q;
    err_d        = err_q;
    if (send && !credit_in) begin
      credit_d = credit_q - 4'd1;
    end else if (!send && credit_in) begin
      // A return beyond the reset grant means the receiver lost track; saturate and flag
      if (credit_q == CRED_MAX) err_d = 1'b1;
      else                      credit_d = credit_q + 4'd1;
    end
  end

  // Link state machine next-state
  always_comb begin
    state_d = state_q;
    if (!link_up) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     if (credit_d == '0 && count_d != '0) state_d = STALL;
        STALL:   if (credit_in) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers; reset discards all buffered flits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      link_valid_q <= 1'b0;
      link_data_q  <= '0;
      credit_q     <= CRED_MAX;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      link_valid_q <= link_valid_d;
      link_data_q  <= link_data_d;
      credit_q     <= credit_d;
      err_q        <= err_d;
    end
  end

  // Payload storage; contents are meaningless until written, so no reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  assign link_valid = link_valid_q;
  assign link_data  = link_data_q;
  assign credit_cnt = credit_q;
  assign credit_err = err_q;

endmodule

// File: tb/tb_router_ilck_tx.sv
// Directed bench for router_ilck_tx: stimulus pushes expected link flits into
// a queue; a negedge monitor pops and compares every flit the DUT sends.
module tb_router_ilck_tx;

  logic        clk = 1'b0;
  logic        reset, in_valid, link_up, credit_in;
  logic [31:0] in_data;
  logic        in_ready, link_valid, credit_err;
  logic [31:0] link_data;
  logic [3:0]  credit_cnt;

  int checks = 0;
  int errors = 0;
  int sent   = 0;
  int sent0;
  logic [31:0] exp_q [$];
  logic [31:0] mon_exp;

  router_ilck_tx #(.DATA_WIDTH(32), .CREDITS(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .link_up(link_up), .credit_in(credit_in),
    .link_valid(link_valid), .link_data(link_data),
    .credit_cnt(credit_cnt), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Offer one flit and hold it until accepted (bounded)
  task automatic push(input logic [31:0] d);
    bit ok = 0;
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (in_ready) begin
        exp_q.push_back(d);
        ok = 1;
      end
      tick();
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: flit %0h never accepted", d);
    end
  endtask

  task automatic credit_pulse();
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (link_valid) begin
      sent++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL link_unexpected: got %0h expected no flit", link_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (link_data !== mon_exp) begin
          errors++;
          $display("FAIL link_data: got %0h expected %0h", link_data, mon_exp);
        end
      end
    end
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = '0; link_up = 1'b0; credit_in = 1'b0;
    ticks(2);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_link_valid", link_valid, 0);
    chk("rst_link_data", link_data, 0);
    chk("rst_credit_cnt", credit_cnt, 4);
    chk("rst_credit_err", credit_err, 0);
    reset = 1'b1;

    // Three flits back to back, sends on edges 2..4
    link_up = 1'b1;
    push(32'hA1);
    chk("t1_no_send_edge1", link_valid, 0);
    push(32'hA2);
    chk("t1_send_edge2", link_valid, 1);
    push(32'hA3);
    chk("t1_send_edge3", link_valid, 1);
    tick();
    chk("t1_send_edge4", link_valid, 1);
    ticks(2);
    chk("t1_credit", credit_cnt, 1);
    chk("t1_idle_valid", link_valid, 0);
    chk("t1_data_hold", link_data, 32'hA3);
    chk("t1_sent", sent, 3);
    for (int i = 0; i < 3; i++) credit_pulse();
    chk("t1_credit_back", credit_cnt, 4);

    // Six flits, four credits: stall, then one credit releases one flit
    sent0 = sent;
    for (int i = 0; i < 6; i++) push(32'hB0 + i);
    ticks(3);
    chk("t2_sent4", sent - sent0, 4);
    chk("t2_credit0", credit_cnt, 0);
    chk("t2_stall_valid", link_valid, 0);
    chk("t2_in_ready", in_ready, 1);
    credit_pulse();
    chk("t2_no_send_on_credit_edge", link_valid, 0);
    chk("t2_credit1", credit_cnt, 1);
    tick();
    chk("t2_fifth_sent", link_valid, 1);
    chk("t2_credit0b", credit_cnt, 0);
    credit_pulse();
    ticks(2);
    chk("t2_sent6", sent - sent0, 6);
    for (int i = 0; i < 4; i++) credit_pulse();
    chk("t2_credit_back", credit_cnt, 4);

    // Credit return coinciding with a send at credit_cnt = 2
    push(32'hC0);
    push(32'hC1);
    ticks(3);
    chk("t3_credit2", credit_cnt, 2);
    in_data = 32'hC2; in_valid = 1'b1;
    exp_q.push_back(32'hC2);
    tick();
    in_valid = 1'b0;
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    chk("t3_send", link_valid, 1);
    chk("t3_credit_same", credit_cnt, 2);
    chk("t3_no_err", credit_err, 0);
    credit_pulse();
    credit_pulse();
    chk("t3_credit_back", credit_cnt, 4);

    // Credit overflow: saturate and latch error
    credit_pulse();
    chk("t4_credit_sat", credit_cnt, 4);
    chk("t4_err_set", credit_err, 1);
    ticks(3);
    chk("t4_err_sticky", credit_err, 1);

    // Link down: fill FIFO without sending, then drain in order
    link_up = 1'b0;
    tick();
    sent0 = sent;
    for (int i = 0; i < 4; i++) push(32'hD0 + i);
    chk("t5_full", in_ready, 0);
    chk("t5_no_send", link_valid, 0);
    ticks(2);
    chk("t5_still_no_send", link_valid, 0);
    chk("t5_credit_kept", credit_cnt, 4);
    link_up = 1'b1;
    ticks(6);
    chk("t5_sent4", sent - sent0, 4);
    chk("t5_ready_back", in_ready, 1);
    chk("t5_credit0", credit_cnt, 0);
    chk("t5_err_still", credit_err, 1);

    // Reset with flits buffered and one credit
    link_up = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) push(32'hE0 + i);
    credit_pulse();
    chk("t6_credit1", credit_cnt, 1);
    chk("t6_fifo_busy", in_ready, 1);
    reset = 1'b0;
    #1;
    exp_q.delete();
    chk("t6_async_valid", link_valid, 0);
    chk("t6_async_credit", credit_cnt, 4);
    chk("t6_async_ready", in_ready, 1);
    chk("t6_async_err", credit_err, 0);
    chk("t6_async_data", link_data, 0);
    tick();
    reset = 1'b1;
    link_up = 1'b1;
    sent0 = sent;
    ticks(6);
    chk("t6_no_stale", sent - sent0, 0);
    chk("t6_credit_full", credit_cnt, 4);

    chk("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
